// File: rtl/audio_preemph.sv
// rtl/audio_preemph.sv - stereo first-order IIR pre-emphasis with one shared multiplier
// Left then right channel are processed in turn; results are published together in DONE.
module audio_preemph #(
  parameter int WIDTH      = 16,
  parameter int COEF_WIDTH = 18,
  parameter int COEF_RADIX = 16,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [WIDTH-1:0]      in_l,
  input  logic signed [WIDTH-1:0]      in_r,
  input  logic                         in_valid,
  input  logic signed [COEF_WIDTH-1:0] b0,
  input  logic signed [COEF_WIDTH-1:0] b1,
  input  logic signed [COEF_WIDTH-1:0] a1,
  input  logic                         bypass,
  input  logic                         clear_overrun,
  output logic signed [WIDTH-1:0]      out_l,
  output logic signed [WIDTH-1:0]      out_r,
  output logic                         out_valid,
  output logic                         busy,
  output logic                         overrun
);

  localparam int PW = WIDTH + COEF_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] HALF =
    {{(ACC_WIDTH-1){1'b0}}, 1'b1} << (COEF_RADIX - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [3:0] {
    IDLE, L0, L1, L2, LS, R0, R1, R2, RS, DONE
  } state_t;

  state_t state, state_next;

  logic signed [WIDTH-1:0]      xl_q, xr_q, xl_d, xr_d, yl_d, yr_d;
  logic signed [COEF_WIDTH-1:0] b0_q, b1_q, a1_q;
  logic                         byp_q;
  logic signed [ACC_WIDTH-1:0]  acc;

  logic signed [WIDTH-1:0]      mul_x;
  logic signed [COEF_WIDTH-1:0] mul_c;
  logic signed [PW-1:0]         prod;
  logic signed [ACC_WIDTH-1:0]  prod_ext, acc_rnd, acc_sh;
  logic signed [WIDTH-1:0]      sat_y;
  logic                         acc_load, acc_add, store_l, store_r, done;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = IDLE;
    unique case (state)
      IDLE:    state_next = in_valid ? L0 : IDLE;
      L0:      state_next = L1;
      L1:      state_next = L2;
      L2:      state_next = LS;
      LS:      state_next = R0;
      R0:      state_next = R1;
      R1:      state_next = R2;
      R2:      state_next = RS;
      RS:      state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / datapath-control logic: multiplier operand select per state
  always_comb begin
    busy     = (state != IDLE);
    mul_x    = xl_q;
    mul_c    = b0_q;
    acc_load = 1'b0;
    acc_add  = 1'b0;
    store_l  = 1'b0;
    store_r  = 1'b0;
    done     = 1'b0;
    unique case (state)
      L0: begin mul_x = xl_q; mul_c = b0_q; acc_load = 1'b1; end
      L1: begin mul_x = xl_d; mul_c = b1_q; acc_add  = 1'b1; end
      L2: begin mul_x = yl_d; mul_c = a1_q; acc_add  = 1'b1; end
      LS: store_l = 1'b1;
      R0: begin mul_x = xr_q; mul_c = b0_q; acc_load = 1'b1; end
      R1: begin mul_x = xr_d; mul_c = b1_q; acc_add  = 1'b1; end
      R2: begin mul_x = yr_d; mul_c = a1_q; acc_add  = 1'b1; end
      RS: store_r = 1'b1;
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign prod     = mul_x * mul_c;
  assign prod_ext = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};

  // Round half up, then clamp to the sample range
  assign acc_rnd = acc + HALF;
  assign acc_sh  = acc_rnd >>> COEF_RADIX;
  always_comb begin
    sat_y = acc_sh[WIDTH-1:0];
    if (acc_sh > SAT_MAX)      sat_y = SAT_MAX[WIDTH-1:0];
    else if (acc_sh < SAT_MIN) sat_y = SAT_MIN[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      xl_q      <= '0;
      xr_q      <= '0;
      xl_d      <= '0;
      xr_d      <= '0;
      yl_d      <= '0;
      yr_d      <= '0;
      b0_q      <= '0;
      b1_q      <= '0;
      a1_q      <= '0;
      byp_q     <= 1'b0;
      acc       <= '0;
      out_l     <= '0;
      out_r     <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (state == IDLE && in_valid) begin
        xl_q  <= in_l;
        xr_q  <= in_r;
        b0_q  <= b0;
        b1_q  <= b1;
        a1_q  <= a1;
        byp_q <= bypass;
      end
      // A drop in the same cycle as a clear keeps the flag set
      if (in_valid && busy)   overrun <= 1'b1;
      else if (clear_overrun) overrun <= 1'b0;
      if (acc_load)     acc <= prod_ext;
      else if (acc_add) acc <= acc + prod_ext;
      if (store_l) begin
        xl_d <= xl_q;
        yl_d <= sat_y;
      end
      if (store_r) begin
        xr_d <= xr_q;
        yr_d <= sat_y;
      end
      if (done) begin
        out_l     <= byp_q ? xl_q : yl_d;
        out_r     <= byp_q ? xr_q : yr_d;
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_audio_preemph.sv
// tb/tb_audio_preemph.sv - directed self-checking bench for audio_preemph
module tb_audio_preemph;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [15:0] in_l, in_r;
  logic               in_valid;
  logic signed [17:0] b0, b1, a1;
  logic               bypass, clear_overrun;
  logic signed [15:0] out_l, out_r;
  logic               out_valid, busy, overrun;

  int checks = 0;
  int failures = 0;

  audio_preemph dut (
    .clk(clk), .reset(reset), .in_l(in_l), .in_r(in_r), .in_valid(in_valid),
    .b0(b0), .b1(b1), .a1(a1), .bypass(bypass), .clear_overrun(clear_overrun),
    .out_l(out_l), .out_r(out_r), .out_valid(out_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_coef(input int c0, input int c1, input int ca);
    b0 = 18'(c0);
    b1 = 18'(c1);
    a1 = 18'(ca);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Send one pair, wait (bounded) for out_valid, check latency and both outputs
  task automatic run_sample(input string tag, input int l, input int r, input int el, input int er);
    int lat;
    in_l = 16'(l);
    in_r = 16'(r);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check({tag, "_busy"}, int'(busy), 1);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 30) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, lat, 10);
    check({tag, "_out_l"}, int'(out_l), el);
    check({tag, "_out_r"}, int'(out_r), er);
  endtask

  initial begin
    int pulses;
    int at;
    int cyc;

    reset = 1'b1; in_l = '0; in_r = '0; in_valid = 1'b0;
    b0 = '0; b1 = '0; a1 = '0; bypass = 1'b0; clear_overrun = 1'b0;
    step();
    step();
    check("rst_out_l", int'(out_l), 0);
    check("rst_out_r", int'(out_r), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);
    reset = 1'b0;

    // Identity
    set_coef(65536, 0, 0);
    run_sample("id0", 1000, -2000, 1000, -2000);
    step();
    check("id0_pulse_end", int'(out_valid), 0);
    run_sample("id1", 32767, -32768, 32767, -32768);

    // FIR step: y = x - 0.5*x[n-1]
    do_reset();
    set_coef(65536, -32768, 0);
    run_sample("fir0", 1000, 0, 1000, 0);
    run_sample("fir1", 1000, 0, 500, 0);
    run_sample("fir2", 1000, 0, 500, 0);

    // IIR decay with a1 = 0.5, round half up on both signs
    do_reset();
    set_coef(65536, 0, 32768);
    run_sample("iir0", 1000, -1000, 1000, -1000);
    run_sample("iir1", 0, 0, 500, -500);
    run_sample("iir2", 0, 0, 250, -250);
    run_sample("iir3", 0, 0, 125, -125);
    run_sample("iir4", 0, 0, 63, -62);
    run_sample("iir5", 0, 0, 32, -31);

    // Saturation
    do_reset();
    set_coef(131071, 0, 0);
    run_sample("sat", 30000, -30000, 32767, -32768);

    // Overrun: second strobe at N+3 is dropped
    do_reset();
    set_coef(65536, 0, 0);
    in_l = 16'sd100; in_r = 16'sd200; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    in_l = 16'sd5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("ovr_set", int'(overrun), 1);
    cyc = 4; pulses = 0; at = 0;
    while (cyc < 16) begin
      step();
      cyc++;
      if (out_valid === 1'b1) begin
        pulses++;
        at = cyc;
        check("ovr_out_l", int'(out_l), 100);
      end
    end
    check("ovr_pulses", pulses, 1);
    check("ovr_pulse_cycle", at, 10);
    clear_overrun = 1'b1;
    step();
    clear_overrun = 1'b0;
    check("ovr_cleared", int'(overrun), 0);
    // Simultaneous clear and drop: set wins
    in_valid = 1'b1;
    step();
    clear_overrun = 1'b1;
    step();
    in_valid = 1'b0;
    clear_overrun = 1'b0;
    check("ovr_set_wins", int'(overrun), 1);
    cyc = 0;
    while (busy === 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    check("ovr_drain", int'(busy), 0);
    clear_overrun = 1'b1;
    step();
    clear_overrun = 1'b0;

    // Bypass, then filtered response resumes from live history
    do_reset();
    set_coef(65536, 0, 32768);
    bypass = 1'b1;
    run_sample("byp0", 1000, -400, 1000, -400);
    run_sample("byp1", 2000, -400, 2000, -400);
    bypass = 1'b0;
    run_sample("byp2", 0, 0, 1250, -300);

    // Reset mid-operation
    in_l = 16'sd7000; in_r = 16'sd7000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_out_l", int'(out_l), 0);
    check("mid_out_r", int'(out_r), 0);
    check("mid_out_valid", int'(out_valid), 0);
    check("mid_busy", int'(busy), 0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid === 1'b1) pulses++;
    end
    check("mid_no_pulse", pulses, 0);
    set_coef(65536, 0, 32768);
    run_sample("mid_after", 1000, 0, 1000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/audio_preemph.md
Name: audio_preemph

Overview:
- Stereo FM pre-emphasis filter directly upstream of the stereo multiplex stage.
- Takes one left/right audio pair per sample strobe and runs a first-order IIR, y[n] = b0·x[n] + b1·x[n-1] + a1·y[n-1], on each channel.
- Both channels share a single multiplier, time-multiplexed by a small state machine.
- Holds the filtered pair on out_l/out_r, which feed the multiplex stage's in_l/in_r and are sampled there on its own subcarrier-phase strobes.

Parameters:
- WIDTH, 16, audio sample width (signed two's complement), in and out.
- COEF_WIDTH, 18, coefficient width (signed).
- COEF_RADIX, 16, fractional bits of coefficients. Default format is Q2.16, range [-2.0, 2.0).
- ACC_WIDTH, 40, accumulator width (signed). Must be ≥ WIDTH+COEF_WIDTH+2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_l  in  WIDTH  left sample, signed
- in_r  in  WIDTH  right sample, signed
- in_valid  in  1  one-cycle sample strobe
- b0  in  COEF_WIDTH  feed-forward coefficient for x[n]
- b1  in  COEF_WIDTH  feed-forward coefficient for x[n-1]
- a1  in  COEF_WIDTH  feedback coefficient for y[n-1]
- bypass  in  1  output raw input instead of filtered value
- clear_overrun  in  1  clears sticky overrun flag
- out_l  out  WIDTH  filtered left, held until next update
- out_r  out  WIDTH  filtered right, held until next update
- out_valid  out  1  one-cycle pulse when out_l/out_r update
- busy  out  1  high while the state machine is not IDLE
- overrun  out  1  sticky: an in_valid arrived while busy

Behaviour:
- Reset: synchronous, active-high. Zeroes all outputs (out_l, out_r, out_valid, busy, overrun) and all internal state (x history, y history, latched coefficients). State goes to IDLE.
- States, one cycle each except IDLE:
  - IDLE
  - L0: acc = b0·xl
  - L1: acc += b1·xl_d
  - L2: acc += a1·yl_d
  - LS: round/saturate and store yl
  - R0, R1, R2, RS: same sequence for the right channel
  - DONE
- IDLE holds until in_valid is sampled high. On that edge: latch in_l, in_r, b0, b1, a1, bypass, then go to L0.
- Coefficient or bypass changes mid-sample take effect on the next accepted sample.
- Sequence: IDLE→L0→L1→L2→LS→R0→R1→R2→RS→DONE→IDLE.
- Latency: in_valid accepted at cycle N → out_valid high in cycle N+10. out_l/out_r change in that same cycle.
- Throughput: one pair per 10 cycles. IDLE can accept again in cycle N+10.
- Multiplier: one signed WIDTH×COEF_WIDTH multiplier, sign-extended into ACC_WIDTH.
- Round/saturate (LS/RS):
  - y = (acc + 2^(COEF_RADIX-1)) >>> COEF_RADIX, i.e. round half up.
  - Saturate y to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- History update (LS/RS):
  - x_d is updated to the current input.
  - y_d is updated to the saturated y, so feedback always uses the saturated value.
- DONE:
  - out_l/out_r take the filtered yl/yr, or the latched raw inputs if bypass was latched.
  - Pulse out_valid for exactly one cycle.
- Bypass: the filter still runs and histories update, so leaving bypass causes no transient beyond the normal response.
- busy = (state != IDLE).
- Overrun:
  - An in_valid seen while busy (including in DONE) is dropped and sets overrun.
  - clear_overrun clears the flag. If clear_overrun and a new drop occur in the same cycle, the set wins.
- Reset mid-operation: state returns to IDLE, no out_valid is issued, histories are cleared.
- Channels never share history; left input never affects right output.

Test Plan:
- Identity: b0=65536, b1=0, a1=0. Drive pairs (1000,-2000) then (32767,-32768). Required: out_l/out_r equal inputs exactly, out_valid exactly 10 cycles after each in_valid.
- FIR step: b0=65536, b1=-32768, a1=0. Drive in_l=1000 on three consecutive samples. Required: out_l = 1000, 500, 500. out_r = 0 with in_r=0.
- IIR decay and rounding: b0=65536, b1=0, a1=32768. Drive in_l impulse 1000 then zeros. Required: out_l = 1000, 500, 250, 125, 63, 32.
- Saturation: b0=131071, b1=0, a1=0. Drive in_l=30000, in_r=-30000. Required: out_l=32767, out_r=-32768.
- Overrun and bypass:
  - Drive in_valid at N and N+3. Required: a single out_valid at N+10, overrun=1, then overrun=0 the cycle after clear_overrun.
  - With bypass=1 and a1=32768: out = raw input, and the filtered response resumes correctly after bypass drops.
- Reset mid-op: in_valid at N, reset at N+5. Required: no out_valid, all outputs 0, busy=0. The next sample in_l=1000 with a1=32768 gives 1000 (history cleared).
